mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the instruction fetch port (IF stage) and the data access port (MEM stage: lw/sw) of the pipelined processor.
- Sequences each RAM access through a fixed-latency handshake.
- Returns read data to the requester that issued the access.
- Raises stall signals that freeze the pipeline while a port's access is pending.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: fetch port, data port, RAM port and pipeline stalls.
// The slave modport is the arbiter's view; master is the pipeline/RAM environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
    output ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports of the pipeline,
// one fixed-latency access at a time, data port first.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : gen_lat_check
    $fatal(1, "mem_port_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
  end

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  localparam logic [3:0] LatInit = 4'(MEM_LAT);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic if_elig;
  logic mem_elig;

  // A request still high in its own ready cycle is the one just served, not a new one.
  assign if_elig  = bus.if_req & ~if_ready_q;
  assign mem_elig = bus.mem_req & ~mem_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_elig) begin
            state_q     <= StBusyMem;
            cnt_q       <= LatInit;
            ram_en_q    <= 1'b1;
            ram_we_q    <= bus.mem_we;
            ram_addr_q  <= bus.mem_addr;
            ram_wdata_q <= bus.mem_wdata;
          end else if (if_elig) begin
            state_q    <= StBusyIf;
            cnt_q      <= LatInit;
            ram_en_q   <= 1'b1;
            ram_addr_q <= bus.if_addr;
          end
        end
        StBusyIf: begin
          if (cnt_q == '0) begin
            if_rdata_q <= bus.ram_rdata;
            if_ready_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StBusyMem: begin
          if (cnt_q == '0) begin
            mem_rdata_q <= bus.ram_rdata;
            mem_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15) sharing one RAM model,
// directed scenarios plus a random two-port run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{2, 1, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        if_req    [NDUT];
  logic [31:0] if_addr   [NDUT];
  logic        mem_req   [NDUT];
  logic        mem_we    [NDUT];
  logic [31:0] mem_addr  [NDUT];
  logic [31:0] mem_wdata [NDUT];
  logic [31:0] ram_rdata [NDUT];
  logic [31:0] if_rdata  [NDUT];
  logic        if_ready  [NDUT];
  logic [31:0] mem_rdata [NDUT];
  logic        mem_ready [NDUT];
  logic        ram_en    [NDUT];
  logic        ram_we    [NDUT];
  logic [31:0] ram_addr  [NDUT];
  logic [31:0] ram_wdata [NDUT];
  logic        stall_if  [NDUT];
  logic        stall_mem [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LATS[k])) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
    assign bus.if_req    = if_req[k];
    assign bus.if_addr   = if_addr[k];
    assign bus.mem_req   = mem_req[k];
    assign bus.mem_we    = mem_we[k];
    assign bus.mem_addr  = mem_addr[k];
    assign bus.mem_wdata = mem_wdata[k];
    assign bus.ram_rdata = ram_rdata[k];
    assign if_rdata[k]   = bus.if_rdata;
    assign if_ready[k]   = bus.if_ready;
    assign mem_rdata[k]  = bus.mem_rdata;
    assign mem_ready[k]  = bus.mem_ready;
    assign ram_en[k]     = bus.ram_en;
    assign ram_we[k]     = bus.ram_we;
    assign ram_addr[k]   = bus.ram_addr;
    assign ram_wdata[k]  = bus.ram_wdata;
    assign stall_if[k]   = bus.stall_if;
    assign stall_mem[k]  = bus.stall_mem;
  end

  int total = 0;
  int bad = 0;

  // ram_mem is the environment RAM (written by DUT outputs); gold_mem is the bench's own view.
  logic [31:0] ram_mem  [logic [31:0]];
  logic [31:0] gold_mem [logic [31:0]];
  logic [31:0] rd_val   [NDUT];
  int          rd_left  [NDUT] = '{0, 0, 0};

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return a ^ 32'h5EED_1234;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] gold_read(input logic [31:0] a);
    return gold_mem.exists(a) ? gold_mem[a] : seed_word(a);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst_n && ram_en[k]) begin
        if (ram_we[k]) ram_mem[ram_addr[k]] = ram_wdata[k];
        else begin
          rd_val[k]  = ram_read(ram_addr[k]);
          rd_left[k] = LATS[k];
        end
      end
    end
  end

  // Read data is valid only in the cycle exactly MEM_LAT after ram_en; noise otherwise.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NDUT; k++) begin
      if (rd_left[k] > 0) begin
        rd_left[k]   = rd_left[k] - 1;
        ram_rdata[k] = (rd_left[k] == 0) ? rd_val[k] : $urandom();
      end else begin
        ram_rdata[k] = $urandom();
      end
    end
  end

  function automatic logic [5:0] ctrl_of(input int k);
    return {ram_en[k], ram_we[k], if_ready[k], mem_ready[k], stall_if[k], stall_mem[k]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NDUT; k++) begin
      if_req[k]    = 1'b0;
      if_addr[k]   = '0;
      mem_req[k]   = 1'b0;
      mem_we[k]    = 1'b0;
      mem_addr[k]  = '0;
      mem_wdata[k] = '0;
    end
  endtask

  task automatic test_reset_fetch(input int k);
    int l = LATS[k];
    logic [5:0] exp;
    ram_mem[32'h3000]  = 32'h3C01_0000;
    gold_mem[32'h3000] = 32'h3C01_0000;
    clear_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      at_sample();
      total++;
      if (ctrl_of(k) !== 6'b0 || ram_addr[k] !== '0 || ram_wdata[k] !== '0 ||
          if_rdata[k] !== '0 || mem_rdata[k] !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut=%0d ctrl=%b addr=%h wdata=%h if_rd=%h mem_rd=%h exp all 0",
                 k, ctrl_of(k), ram_addr[k], ram_wdata[k], if_rdata[k], mem_rdata[k]);
      end
    end
    next_cycle();
    rst_n      = 1'b1;
    if_req[k]  = 1'b1;
    if_addr[k] = 32'h0000_3000;
    for (int c = 0; c <= l + 2; c++) begin
      if (c > 0) next_cycle();
      at_sample();
      exp = {c == 1, 1'b0, c == l + 2, 1'b0, c < l + 2, 1'b0};
      total++;
      if (ctrl_of(k) !== exp) begin
        bad++;
        $display("FAIL fetch_ctrl dut=%0d cyc=%0d got=%b exp=%b", k, c, ctrl_of(k), exp);
      end
      if (c == 1) begin
        total++;
        if (ram_addr[k] !== 32'h3000) begin
          bad++;
          $display("FAIL fetch_addr dut=%0d got=%h exp=00003000", k, ram_addr[k]);
        end
      end
      if (c == l + 2) begin
        total++;
        if (if_rdata[k] !== 32'h3C01_0000) begin
          bad++;
          $display("FAIL fetch_data dut=%0d got=%h exp=3c010000", k, if_rdata[k]);
        end
      end
    end
    next_cycle();
    if_req[k] = 1'b0;
    at_sample();
  endtask

  task automatic test_store();
    int l = LATS[0];
    logic [5:0] exp;
    next_cycle();
    mem_req[0]   = 1'b1;
    mem_we[0]    = 1'b1;
    mem_addr[0]  = 32'h10;
    mem_wdata[0] = 32'hDEAD_BEEF;
    gold_mem[32'h10] = 32'hDEAD_BEEF;
    for (int c = 0; c <= l + 2; c++) begin
      if (c > 0) next_cycle();
      at_sample();
      exp = {c == 1, c == 1, 1'b0, c == l + 2, 1'b0, c < l + 2};
      total++;
      if (ctrl_of(0) !== exp) begin
        bad++;
        $display("FAIL store_ctrl cyc=%0d got=%b exp=%b", c, ctrl_of(0), exp);
      end
      if (c == 1) begin
        total++;
        if (ram_addr[0] !== 32'h10 || ram_wdata[0] !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL store_bus addr=%h wdata=%h exp addr=00000010 wdata=deadbeef",
                   ram_addr[0], ram_wdata[0]);
        end
      end
    end
    next_cycle();
    mem_req[0] = 1'b0;
    mem_we[0]  = 1'b0;
    at_sample();
  endtask

  task automatic test_simultaneous();
    int l = LATS[0];
    logic [5:0]  exp;
    logic [31:0] ld;
    ld = $urandom();
    ram_mem[32'h20]  = ld;
    gold_mem[32'h20] = ld;
    next_cycle();
    if_req[0]   = 1'b1;
    if_addr[0]  = 32'h3000;
    mem_req[0]  = 1'b1;
    mem_we[0]   = 1'b0;
    mem_addr[0] = 32'h20;
    for (int c = 0; c <= 2 * l + 4; c++) begin
      if (c > 0) next_cycle();
      if (c == l + 3) mem_req[0] = 1'b0;
      at_sample();
      exp = {c == 1 || c == l + 3, 1'b0, c == 2 * l + 4, c == l + 2, c < 2 * l + 4, c < l + 2};
      total++;
      if (ctrl_of(0) !== exp) begin
        bad++;
        $display("FAIL simul_ctrl cyc=%0d got=%b exp=%b", c, ctrl_of(0), exp);
      end
      if (c == 1 || c == l + 3) begin
        total++;
        if (ram_addr[0] !== (c == 1 ? 32'h20 : 32'h3000)) begin
          bad++;
          $display("FAIL simul_addr cyc=%0d got=%h exp=%h", c, ram_addr[0],
                   (c == 1 ? 32'h20 : 32'h3000));
        end
      end
      if (c == l + 2) begin
        total++;
        if (mem_rdata[0] !== ld) begin
          bad++;
          $display("FAIL simul_mem_data got=%h exp=%h", mem_rdata[0], ld);
        end
      end
      if (c == 2 * l + 4) begin
        total++;
        if (if_rdata[0] !== gold_read(32'h3000)) begin
          bad++;
          $display("FAIL simul_if_data got=%h exp=%h", if_rdata[0], gold_read(32'h3000));
        end
      end
    end
    next_cycle();
    if_req[0] = 1'b0;
    at_sample();
  endtask

  task automatic test_held_request();
    int l = LATS[0];
    logic [5:0]  exp;
    logic [31:0] w2;
    logic        rdy;
    w2 = $urandom();
    ram_mem[32'h3004]  = w2;
    gold_mem[32'h3004] = w2;
    next_cycle();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h3000;
    for (int c = 0; c <= 2 * l + 5; c++) begin
      if (c > 0) next_cycle();
      if (c == l + 3) if_addr[0] = 32'h3004;
      at_sample();
      rdy = (c == l + 2) || (c == 2 * l + 5);
      exp = {c == 1 || c == l + 4, 1'b0, rdy, 1'b0, !rdy, 1'b0};
      total++;
      if (ctrl_of(0) !== exp) begin
        bad++;
        $display("FAIL held_ctrl cyc=%0d got=%b exp=%b", c, ctrl_of(0), exp);
      end
      if (c == l + 4) begin
        total++;
        if (ram_addr[0] !== 32'h3004) begin
          bad++;
          $display("FAIL held_addr got=%h exp=00003004", ram_addr[0]);
        end
      end
      if (c == 2 * l + 5) begin
        total++;
        if (if_rdata[0] !== w2) begin
          bad++;
          $display("FAIL held_data got=%h exp=%h", if_rdata[0], w2);
        end
      end
    end
    next_cycle();
    if_req[0] = 1'b0;
    at_sample();
  endtask

  task automatic test_reset_mid_access();
    int l = LATS[0];
    logic [5:0]  exp;
    logic [31:0] a;
    logic [31:0] d;
    a = 32'h8000_0100 | ($urandom_range(0, 15) << 2);
    d = $urandom();
    ram_mem[a]  = d;
    gold_mem[a] = d;
    next_cycle();
    mem_req[0]  = 1'b1;
    mem_we[0]   = 1'b0;
    mem_addr[0] = a;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      if (c == 2) begin
        rst_n      = 1'b0;
        mem_req[0] = 1'b0;
      end
      if (c == 3) rst_n = 1'b1;
      at_sample();
      exp = {c == 1, 4'b0, c < 2};
      total++;
      if (ctrl_of(0) !== exp) begin
        bad++;
        $display("FAIL rstmid_ctrl cyc=%0d got=%b exp=%b", c, ctrl_of(0), exp);
      end
      if (c >= 3) begin
        total++;
        if (mem_rdata[0] !== '0) begin
          bad++;
          $display("FAIL rstmid_rdata cyc=%0d got=%h exp=00000000", c, mem_rdata[0]);
        end
      end
    end
    a = 32'h8000_0200 | ($urandom_range(0, 15) << 2);
    d = $urandom();
    ram_mem[a]  = d;
    gold_mem[a] = d;
    next_cycle();
    mem_req[0]  = 1'b1;
    mem_addr[0] = a;
    for (int c = 0; c <= l + 2; c++) begin
      if (c > 0) next_cycle();
      at_sample();
      exp = {c == 1, 2'b0, c == l + 2, 1'b0, c < l + 2};
      total++;
      if (ctrl_of(0) !== exp) begin
        bad++;
        $display("FAIL rstmid_after_ctrl cyc=%0d got=%b exp=%b", c, ctrl_of(0), exp);
      end
      if (c == l + 2) begin
        total++;
        if (mem_rdata[0] !== d) begin
          bad++;
          $display("FAIL rstmid_after_data got=%h exp=%h", mem_rdata[0], d);
        end
      end
    end
    next_cycle();
    mem_req[0] = 1'b0;
    at_sample();
  endtask

  task automatic test_latency_sweep();
    test_reset_fetch(1);
    test_reset_fetch(2);
  endtask

  // Transaction-level model: one access at a time, ready MEM_LAT+2 cycles after the grant,
  // data port preferred, a port not re-granted in its own ready cycle.
  task automatic test_random(input int n_cycles);
    int          l = LATS[0];
    bit          if_pend = 0, mem_pend = 0, mem_w = 0;
    logic [31:0] if_a = '0, mem_a = '0, mem_d = '0;
    bit          busy = 0, busy_mem = 0, acc_we = 0;
    int          rdy_c = -10, en_c = -10, if_rdy_c = -10, mem_rdy_c = -10;
    logic [31:0] acc_addr = '0, acc_wdata = '0, acc_data = '0;
    logic [31:0] if_hold = '0, mem_hold = '0;
    bit          mem_hold_ok = 1, exp_ifr, exp_mr, exp_en;
    logic [5:0]  exp;
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < n_cycles; c++) begin
      if (c > 0) next_cycle();
      if (if_pend && if_rdy_c == c - 1) if_pend = 0;
      if (mem_pend && mem_rdy_c == c - 1) mem_pend = 0;
      if (!if_pend && $urandom_range(0, 1) == 0) begin
        if_pend = 1;
        if_a    = 32'hF000_0000 | ($urandom_range(0, 15) << 2);
      end
      if (!mem_pend && $urandom_range(0, 1) == 0) begin
        mem_pend = 1;
        mem_w    = 1'($urandom_range(0, 1));
        mem_a    = 32'h8000_0000 | ($urandom_range(0, 7) << 2);
        mem_d    = $urandom();
      end
      if_req[0]    = if_pend;
      if_addr[0]   = if_pend ? if_a : $urandom();
      mem_req[0]   = mem_pend;
      mem_we[0]    = mem_pend ? mem_w : 1'($urandom_range(0, 1));
      mem_addr[0]  = mem_pend ? mem_a : $urandom();
      mem_wdata[0] = mem_pend ? mem_d : $urandom();

      exp_ifr = 0;
      exp_mr  = 0;
      if (busy && c == rdy_c) begin
        busy = 0;
        if (busy_mem) begin
          exp_mr    = 1;
          mem_rdy_c = c;
          mem_hold_ok = !acc_we;
          if (!acc_we) mem_hold = acc_data;
        end else begin
          exp_ifr  = 1;
          if_rdy_c = c;
          if_hold  = acc_data;
        end
      end
      exp_en = (c == en_c);
      if (!busy && ((mem_pend && !exp_mr) || (if_pend && !exp_ifr))) begin
        busy     = 1;
        busy_mem = mem_pend && !exp_mr;
        rdy_c    = c + l + 2;
        en_c     = c + 1;
        if (busy_mem) begin
          acc_we    = mem_w;
          acc_addr  = mem_a;
          acc_wdata = mem_d;
          acc_data  = gold_read(mem_a);
          if (mem_w) gold_mem[mem_a] = mem_d;
        end else begin
          acc_we   = 0;
          acc_addr = if_a;
          acc_data = gold_read(if_a);
        end
      end

      at_sample();
      exp = {exp_en, exp_en & acc_we, exp_ifr, exp_mr, if_pend & ~exp_ifr, mem_pend & ~exp_mr};
      total++;
      if (ctrl_of(0) !== exp) begin
        bad++;
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, ctrl_of(0), exp);
      end
      if (exp_en) begin
        total++;
        if (ram_addr[0] !== acc_addr || (acc_we && ram_wdata[0] !== acc_wdata)) begin
          bad++;
          $display("FAIL rand_bus cyc=%0d addr=%h wdata=%h exp addr=%h wdata=%h we=%0b",
                   c, ram_addr[0], ram_wdata[0], acc_addr, acc_wdata, acc_we);
        end
      end
      total++;
      if (if_rdata[0] !== if_hold) begin
        bad++;
        $display("FAIL rand_if_rdata cyc=%0d got=%h exp=%h", c, if_rdata[0], if_hold);
      end
      if (mem_hold_ok) begin
        total++;
        if (mem_rdata[0] !== mem_hold) begin
          bad++;
          $display("FAIL rand_mem_rdata cyc=%0d got=%h exp=%h", c, mem_rdata[0], mem_hold);
        end
      end
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b0;
    at_sample();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset_fetch(0);
    test_store();
    test_simultaneous();
    test_held_request();
    test_reset_mid_access();
    test_latency_sweep();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
